// File: rtl/scazator_serial_4_biti_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the bit-counter width helper.
package scazator_serial_4_biti_pkg;

    // Default operand/result width of the serial subtractor.
    localparam int DEFAULT_WIDTH = 4;

    // Bit counter width for a given operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Bit counter width for the default configuration.
    localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

    // Controller states: waiting, one bit per cycle, result publication.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/scazator_serial_4_biti_1_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
// Used once by the serial datapath; also suitable for a parallel subtractor.
module scazator_1_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/scazator_serial_4_biti.sv
// Bit-serial subtractor: D = A - B - BIN, LSB first, one bit per clock.
// Operands are captured on START in IDLE; the result is published with a
// one-cycle DONE pulse and held until the next completed operation.
module scazator_serial_4_biti
    import scazator_serial_4_biti_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             Z
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             shift;
    logic             finish;

    logic             d_bit;
    logic             br_next;

    // One full-subtractor cell processes the current LSBs of the operands.
    scazator_1_bit u_bit (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // State register; reset returns the controller to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; START only matters while IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        BUSY       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                BUSY  = 1'b1;
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                BUSY       = 1'b1;
                finish     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa  <= '0;
            sb  <= '0;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa  <= A;
            sb  <= B;
            sd  <= '0;
            br  <= BIN;
            cnt <= '0;
        end else if (shift) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            sd  <= {d_bit, sd[WIDTH-1:1]};
            br  <= br_next;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Published result and DONE pulse; outputs only change when FIN completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            D    <= '0;
            BOUT <= 1'b0;
            Z    <= 1'b0;
            DONE <= 1'b0;
        end else begin
            DONE <= finish;
            if (finish) begin
                D    <= sd;
                BOUT <= br;
                Z    <= (sd == '0);
            end
        end
    end

endmodule

// File: tb/tb_scazator_serial_4_biti.sv
// Self-checking bench for the bit-serial subtractor: reset state, directed
// vectors, START-while-busy, reset mid-operation, random ops and a full
// sweep with START held high.
module tb_scazator_serial_4_biti;

    localparam int W       = 4;
    localparam int LATENCY = W + 2;
    localparam int LIMIT   = 40;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] D;
    logic         BOUT;
    logic         Z;

    int checks;
    int failures;
    logic [W-1:0] last_d;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
        logic         exp_z;
    } vec_t;

    vec_t vecs[6];

    scazator_serial_4_biti #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT),
        .Z     (Z)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference: unsigned subtraction widened by one bit gives {borrow, diff}.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        return (W+1)'(diff);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Runs one operation from IDLE and reports result, latency and busy time.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] got_d, output logic got_bout, output logic got_z,
                                  output int edges, output int busy_cycles, output bit held, output bit done_late);
        @(negedge CLK);
        START = 1'b1;
        A     = a;
        B     = b;
        BIN   = bin;
        @(negedge CLK);
        START       = 1'b0;
        A           = ~a;
        B           = ~b;
        BIN         = ~bin;
        edges       = 1;
        busy_cycles = 0;
        held        = 1'b1;
        while (!DONE && edges < LIMIT) begin
            if (BUSY) busy_cycles++;
            if (D !== last_d) held = 1'b0;
            @(negedge CLK);
            edges++;
        end
        got_d     = D;
        got_bout  = BOUT;
        got_z     = Z;
        done_late = !DONE;
        check_output("busy_low_at_done", 32'(BUSY), 32'd0);
        @(negedge CLK);
        check_output("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    // Runs an operation and compares everything against the expectations.
    task automatic run_and_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_z);
        logic [W-1:0] gd;
        logic         gb;
        logic         gz;
        int           edges;
        int           busy_cycles;
        bit           held;
        bit           late;
        apply_stimulus(a, b, bin, gd, gb, gz, edges, busy_cycles, held, late);
        check_output("done_timeout", 32'(late), 32'd0);
        check_output("d", 32'(gd), 32'(exp_d));
        check_output("bout", 32'(gb), 32'(exp_bout));
        check_output("z", 32'(gz), 32'(exp_z));
        check_output("latency_edges", 32'(edges), 32'(LATENCY));
        check_output("busy_cycles", 32'(busy_cycles), 32'(W + 1));
        check_output("d_held_until_done", 32'(held), 32'd1);
        last_d = exp_d;
    endtask

    initial begin
        logic [W:0] r;
        int done_count;
        int prev_done;
        int cyc;
        bit held;
        checks   = 0;
        failures = 0;
        last_d   = '0;
        RST      = 1'b1;
        START    = 1'b0;
        A        = '0;
        B        = '0;
        BIN      = 1'b0;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[3] = '{4'd9,  4'd9,  1'b0, 4'd0,  1'b0, 1'b1};
        vecs[4] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_output("rst_busy", 32'(BUSY), 32'd0);
        check_output("rst_done", 32'(DONE), 32'd0);
        check_output("rst_d", 32'(D), 32'd0);
        check_output("rst_bout", 32'(BOUT), 32'd0);
        check_output("rst_z", 32'(Z), 32'd0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_and_check(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_z);
        end

        // START pulsed while busy is ignored: only 7 - 1 completes
        @(negedge CLK);
        START = 1'b1; A = 4'd7; B = 4'd1; BIN = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1; A = 4'd2; B = 4'd4;
        @(negedge CLK);
        START = 1'b0;
        done_count = 0;
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (DONE) begin
                done_count++;
                check_output("busy_start_d", 32'(D), 32'd6);
            end else if (done_count == 0 && D !== last_d) begin
                held = 1'b0;
            end
            @(negedge CLK);
        end
        check_output("busy_start_done_count", 32'(done_count), 32'd1);
        check_output("busy_start_d_held", 32'(held), 32'd1);
        last_d = 4'd6;

        // Reset in the second SHIFT cycle aborts the operation
        START = 1'b1; A = 4'd12; B = 4'd3; BIN = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_output("abort_busy", 32'(BUSY), 32'd0);
        check_output("abort_d", 32'(D), 32'd0);
        check_output("abort_bout", 32'(BOUT), 32'd0);
        check_output("abort_z", 32'(Z), 32'd0);
        done_count = 0;
        for (int c = 0; c < 10; c++) begin
            if (DONE) done_count++;
            @(negedge CLK);
        end
        check_output("abort_no_done", 32'(done_count), 32'd0);
        last_d = '0;
        run_and_check(4'd12, 4'd3, 1'b0, 4'd9, 1'b0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            ra   = W'($urandom_range(0, (1 << W) - 1));
            rb   = W'($urandom_range(0, (1 << W) - 1));
            rbin = 1'($urandom_range(0, 1));
            r    = ref_sub(ra, rb, rbin);
            run_and_check(ra, rb, rbin, r[W-1:0], r[W], (r[W-1:0] == '0));
        end

        // Exhaustive sweep with START held high
        @(negedge CLK);
        START = 1'b1;
        A = '0; B = '0; BIN = 1'b0;
        prev_done = -1;
        cyc = 0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            logic [W-1:0] sa;
            logic [W-1:0] sb;
            logic         sbin;
            int           waited;
            idx  = 9'(i);
            sa   = idx[8:5];
            sb   = idx[4:1];
            sbin = idx[0];
            A = sa; B = sb; BIN = sbin;
            waited = 0;
            @(negedge CLK);
            cyc++;
            while (!DONE && waited < LIMIT) begin
                @(negedge CLK);
                cyc++;
                waited++;
            end
            if (!DONE) begin
                check_output("sweep_timeout", 32'd1, 32'd0);
                break;
            end
            r = ref_sub(sa, sb, sbin);
            check_output("sweep_d", 32'(D), 32'(r[W-1:0]));
            check_output("sweep_bout", 32'(BOUT), 32'(r[W]));
            if (prev_done >= 0) begin
                check_output("sweep_done_spacing", 32'(cyc - prev_done), 32'(LATENCY));
            end
            prev_done = cyc;
        end
        START = 1'b0;
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
